// File: rtl/cmul_pkg.sv
// Shared constants, sideband type and clamp limits for the pipelined
// complex multiplier (cmul_conj_pipe) and its round/saturate helper.
package cmul_pkg;

  // Default operand/result width and Q-format fractional bits.
  localparam int CMUL_WIDTH = 26;
  localparam int CMUL_FRAC  = 10;

  // Full product width: a (WIDTH+1)x(WIDTH+1) Gauss product never overflows this.
  localparam int PW = 2 * CMUL_WIDTH + 2;

  // Half-LSB rounding constant for the default fractional width.
  localparam longint ROUND_C = 64'sd1 <<< (CMUL_FRAC - 1);

  // Per-sample control that travels alongside the data through the pipe.
  typedef struct packed {
    logic conj;
    logic last;
  } side_t;

  // Largest representable signed value of the given width.
  function automatic logic signed [127:0] sat_max(input int width);
    return (128'sd1 <<< (width - 1)) - 128'sd1;
  endfunction

  // Most negative representable signed value of the given width.
  function automatic logic signed [127:0] sat_min(input int width);
    return -(128'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and clamp of one
// full-precision product component down to WIDTH bits, with a clamp flag.
// FRAC must be at least 1.
module cmul_round_sat
  import cmul_pkg::*;
#(
  parameter int WIDTH = CMUL_WIDTH,
  parameter int FRAC  = CMUL_FRAC
) (
  input  logic signed [2*WIDTH+1:0] i_val,
  output logic signed [WIDTH-1:0]   o_val,
  output logic                      o_sat
);

  localparam int L_PW = 2 * WIDTH + 2;

  // One extra bit of headroom so adding the half-LSB can never wrap.
  localparam logic signed [L_PW:0]    L_RND = (L_PW + 1)'(1) << (FRAC - 1);
  localparam logic signed [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

  logic signed [L_PW:0]  w_sum;
  logic signed [L_PW:0]  w_shr;
  logic signed [127:0]   w_wide;

  assign w_sum  = $signed({i_val[L_PW-1], i_val}) + L_RND;
  assign w_shr  = w_sum >>> FRAC;
  assign w_wide = 128'(w_shr);

  // Clamp the rounded value into the signed WIDTH-bit range.
  always_comb begin
    o_val = w_shr[WIDTH-1:0];
    o_sat = 1'b0;
    if (w_wide > sat_max(WIDTH)) begin
      o_val = L_MAX;
      o_sat = 1'b1;
    end else if (w_wide < sat_min(WIDTH)) begin
      o_val = L_MIN;
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/cmul_conj_pipe.sv
// Three-stage streaming complex multiplier: m = a * conj(b) when in_conj=1,
// m = a * b otherwise. Gauss 3-multiplier form, round-half-up, saturation.
// One global enable stalls every stage at once; in_ready therefore depends
// combinationally on out_ready (no skid buffer).
module cmul_conj_pipe
  import cmul_pkg::*;
#(
  parameter int WIDTH = CMUL_WIDTH,
  parameter int FRAC  = CMUL_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_conj,
  input  logic                    in_last,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] m_re,
  output logic signed [WIDTH-1:0] m_im,
  output logic                    out_last,
  output logic                    out_sat
);

  localparam int L_PW = 2 * WIDTH + 2;
  localparam int L_SW = WIDTH + 1;

  logic w_en;

  // Stage 1 state
  logic                    r_v1;
  side_t                   r_side1;
  logic signed [WIDTH-1:0] r_a_re1;
  logic signed [WIDTH-1:0] r_a_im1;
  logic signed [WIDTH-1:0] r_b_re1;
  logic signed [WIDTH-1:0] r_b_im1;
  logic signed [L_SW-1:0]  r_pa1;
  logic signed [L_SW-1:0]  r_pb1;

  // Stage 2 state
  logic                    r_v2;
  side_t                   r_side2;
  logic signed [L_PW-1:0]  r_p1;
  logic signed [L_PW-1:0]  r_p2;
  logic signed [L_PW-1:0]  r_p3;

  // Stage 3 (output) state
  logic                    r_v3;
  logic                    r_last3;
  logic                    r_sat3;
  logic signed [WIDTH-1:0] r_m_re;
  logic signed [WIDTH-1:0] r_m_im;

  // Combinational intermediates
  logic signed [L_SW-1:0]  w_pa;
  logic signed [L_SW-1:0]  w_pb;
  logic signed [L_SW-1:0]  w_b_im_x;
  logic signed [L_PW-1:0]  w_p1;
  logic signed [L_PW-1:0]  w_p2;
  logic signed [L_PW-1:0]  w_p3;
  logic signed [L_PW-1:0]  w_comb [2];
  logic signed [WIDTH-1:0] w_rs   [2];
  logic [1:0]              w_sat;

  // Everything advances together unless a valid result is waiting downstream.
  assign w_en     = ~r_v3 | out_ready;
  assign in_ready = w_en;

  // Pre-adds; negating b_im here turns the same datapath into a * conj(b).
  assign w_b_im_x = in_conj ? -L_SW'(b_im) : L_SW'(b_im);
  assign w_pa     = L_SW'(a_re) + L_SW'(a_im);
  assign w_pb     = L_SW'(b_re) + w_b_im_x;

  // Full-precision products; operands are widened first so nothing truncates.
  assign w_p1 = L_PW'(r_a_re1) * L_PW'(r_b_re1);
  assign w_p2 = L_PW'(r_a_im1) * L_PW'(r_b_im1);
  assign w_p3 = L_PW'(r_pa1) * L_PW'(r_pb1);

  // Gauss recombination; the conj flag flips the sign of the b_im terms.
  assign w_comb[0] = r_side2.conj ? (r_p1 + r_p2) : (r_p1 - r_p2);
  assign w_comb[1] = r_side2.conj ? (r_p3 - r_p1 + r_p2) : (r_p3 - r_p1 - r_p2);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
      cmul_round_sat #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
      ) u_rs (
        .i_val(w_comb[gi]),
        .o_val(w_rs[gi]),
        .o_sat(w_sat[gi])
      );
    end
  endgenerate

  // Stage 1: capture operands and control, register the pre-add sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_side1 <= '0;
      r_a_re1 <= '0;
      r_a_im1 <= '0;
      r_b_re1 <= '0;
      r_b_im1 <= '0;
      r_pa1   <= '0;
      r_pb1   <= '0;
    end else if (w_en) begin
      r_v1         <= in_valid;
      r_side1.conj <= in_conj;
      r_side1.last <= in_last;
      r_a_re1      <= a_re;
      r_a_im1      <= a_im;
      r_b_re1      <= b_re;
      r_b_im1      <= b_im;
      r_pa1        <= w_pa;
      r_pb1        <= w_pb;
    end
  end

  // Stage 2: register the three partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_side2 <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_p3    <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_side2 <= r_side1;
      r_p1    <= w_p1;
      r_p2    <= w_p2;
      r_p3    <= w_p3;
    end
  end

  // Stage 3: register the rounded, saturated result and its sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_last3 <= 1'b0;
      r_sat3  <= 1'b0;
      r_m_re  <= '0;
      r_m_im  <= '0;
    end else if (w_en) begin
      r_v3    <= r_v2;
      r_last3 <= r_side2.last;
      r_sat3  <= w_sat[0] | w_sat[1];
      r_m_re  <= w_rs[0];
      r_m_im  <= w_rs[1];
    end
  end

  assign out_valid = r_v3;
  assign out_last  = r_last3;
  assign out_sat   = r_sat3;
  assign m_re      = r_m_re;
  assign m_im      = r_m_im;

endmodule

// File: tb/tb_cmul_conj_pipe.sv
// Scoreboard bench for cmul_conj_pipe: stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_cmul_conj_pipe;

  localparam int W = 26;
  localparam logic signed [W-1:0] VMAX = 26'h1FFFFFF;
  localparam logic signed [W-1:0] VMIN = 26'h2000000;

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic                last;
    logic                sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_conj = 1'b0;
  logic in_last = 1'b0;
  logic signed [W-1:0] a_re = '0;
  logic signed [W-1:0] a_im = '0;
  logic signed [W-1:0] b_re = '0;
  logic signed [W-1:0] b_im = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [W-1:0] m_re;
  logic signed [W-1:0] m_im;
  logic out_last;
  logic out_sat;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic hold_prev = 1'b0;
  logic signed [W-1:0] h_re, h_im;
  logic h_last, h_sat;
  logic done_rand;

  always #5 clk = ~clk;

  cmul_conj_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_conj(in_conj), .in_last(in_last),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .m_re(m_re), .m_im(m_im),
    .out_last(out_last), .out_sat(out_sat)
  );

  // Reference: direct complex product, round half up, clamp.
  function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                 input longint bi, input logic cj, input logic lst);
    exp_t   e;
    longint re, im;
    logic   s;
    if (cj) begin
      re = ar * br + ai * bi;
      im = ai * br - ar * bi;
    end else begin
      re = ar * br - ai * bi;
      im = ai * br + ar * bi;
    end
    re = (re + 512) >>> 10;
    im = (im + 512) >>> 10;
    s = 1'b0;
    if (re > 33554431) begin re = 33554431; s = 1'b1; end
    if (re < -33554432) begin re = -33554432; s = 1'b1; end
    if (im > 33554431) begin im = 33554431; s = 1'b1; end
    if (im < -33554432) begin im = -33554432; s = 1'b1; end
    e.re = W'(re);
    e.im = W'(im);
    e.last = lst;
    e.sat = s;
    return e;
  endfunction

  function automatic logic signed [W-1:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case (r[31:29])
      3'd0:    return VMIN;
      3'd1:    return VMAX;
      3'd2:    return W'($signed(r[11:0]));
      3'd3:    return W'($signed(r[15:0]));
      default: return r[W-1:0];
    endcase
  endfunction

  // Present one sample, wait (bounded) for acceptance, then record the expectation.
  task automatic drive(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                       input logic signed [W-1:0] br, input logic signed [W-1:0] bi,
                       input logic cj, input logic lst, input exp_t e);
    int n;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_conj = cj; in_last = lst; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_re = rnd_val(); a_im = rnd_val(); b_re = rnd_val(); b_im = rnd_val();
    in_conj = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic send_model(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                            input logic signed [W-1:0] br, input logic signed [W-1:0] bi,
                            input logic cj, input logic lst);
    drive(ar, ai, br, bi, cj, lst, model(ar, ai, br, bi, cj, lst));
  endtask

  task automatic send_exp(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                          input logic signed [W-1:0] br, input logic signed [W-1:0] bi,
                          input logic cj, input logic lst, input logic signed [W-1:0] er,
                          input logic signed [W-1:0] ei, input logic es);
    exp_t e;
    e.re = er; e.im = ei; e.last = lst; e.sat = es;
    drive(ar, ai, br, bi, cj, lst, e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // A held output is abandoned by reset.
  initial forever begin
    @(negedge rst_n);
    hold_prev = 1'b0;
  end

  // Monitor: handshake rule, output stability under stall, scoreboard compare.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      total++;
      if (out_valid !== 1'b0 || m_re !== '0 || m_im !== '0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: valid=%0b re=%0d im=%0d last=%0b sat=%0b, required all 0",
                 out_valid, m_re, m_im, out_last, out_sat);
      end
    end else begin
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL in_ready: got %0b, required %0b (out_valid=%0b out_ready=%0b)",
                 in_ready, !out_valid || out_ready, out_valid, out_ready);
      end
      if (hold_prev) begin
        total++;
        if (out_valid !== 1'b1 || m_re !== h_re || m_im !== h_im || out_last !== h_last || out_sat !== h_sat) begin
          bad++;
          $display("FAIL stall_stable: got v=%0b (%0d,%0d) l=%0b s=%0b, required v=1 (%0d,%0d) l=%0b s=%0b",
                   out_valid, m_re, m_im, out_last, out_sat, h_re, h_im, h_last, h_sat);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got (%0d,%0d) with nothing outstanding", m_re, m_im);
        end else begin
          e = sb.pop_front();
          if (m_re !== e.re || m_im !== e.im || out_last !== e.last || out_sat !== e.sat) begin
            bad++;
            $display("FAIL result: got (%0d,%0d) last=%0b sat=%0b, required (%0d,%0d) last=%0b sat=%0b",
                     m_re, m_im, out_last, out_sat, e.re, e.im, e.last, e.sat);
          end else begin
            $display("ok result (%0d,%0d) last=%0b sat=%0b", m_re, m_im, out_last, out_sat);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      h_re = m_re; h_im = m_im; h_last = out_last; h_sat = out_sat;
    end
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Unit rotation, plus first-sample latency on an empty pipe.
    send_exp(1024, 0, 0, 1024, 1'b1, 1'b0, 0, -1024, 1'b0);
    lat = 1;
    begin : lat_loop
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) disable lat_loop;
        @(posedge clk);
        lat++;
      end
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL latency: got %0d edges, required 3", lat);
    end
    @(posedge clk); #1;
    send_exp(1024, 0, 0, 1024, 1'b0, 1'b1, 0, 1024, 1'b0);

    // (3-2j)(0.5-1.5j) = -1.5-5.5j ; (3-2j)(0.5+1.5j) = 4.5+3.5j
    send_exp(3072, -2048, 512, 1536, 1'b1, 1'b0, -1536, -5632, 1'b0);
    send_exp(3072, -2048, 512, 1536, 1'b0, 1'b0, 4608, 3584, 1'b0);

    // Half-LSB rounding at both signs.
    send_exp(1, 0, 512, 0, 1'b0, 1'b0, 1, 0, 1'b0);
    send_exp(-1, 0, 512, 0, 1'b0, 1'b1, 0, 0, 1'b0);

    // Saturation at full-scale operands.
    send_exp(VMAX, VMAX, VMAX, VMAX, 1'b0, 1'b0, 0, VMAX, 1'b1);
    send_exp(VMAX, VMAX, VMAX, VMAX, 1'b1, 1'b0, VMAX, 0, 1'b1);
    send_model(VMIN, VMIN, VMIN, VMIN, 1'b0, 1'b0);
    send_model(VMIN, VMIN, VMIN, VMIN, 1'b1, 1'b1);
    send_model(VMIN, VMAX, VMAX, VMIN, 1'b0, 1'b0);
    send_model(VMIN, 0, 1024, 0, 1'b1, 1'b0);
    wait_drain();

    // Backpressure: 8 back-to-back samples, out_ready low for 4 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_model(rnd_val(), rnd_val(), rnd_val(), rnd_val(),
                     1'($urandom_range(0, 1)), 1'(i == 3 || i == 7));
      end
      begin
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomized traffic with random input gaps and random backpressure.
    done_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          send_model(rnd_val(), rnd_val(), rnd_val(), rnd_val(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with samples in flight and one result stalled at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_model(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %0b, required 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: out_valid=%0b, required 0", out_valid);
    end
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_after_reset: out_valid=%0b (%0d,%0d), required 0", out_valid, m_re, m_im);
      end
    end

    // Pipeline still healthy after reset.
    @(posedge clk); #1;
    send_exp(3072, -2048, 512, 1536, 1'b1, 1'b1, -1536, -5632, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
